// File: rtl/text_pkg.sv
// Shared constants for the text RAM writer: screen geometry, ASCII control
// codes and the writer state encoding.
package text_pkg;

    localparam int unsigned TEXT_COLS = 32;
    localparam int unsigned TEXT_ROWS = 32;

    localparam logic [7:0] ASCII_BS        = 8'h08;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] ASCII_FF        = 8'h0C;
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;

    typedef enum logic [1:0] {
        ST_CLEAR_SCREEN,
        ST_CLEAR_ROW,
        ST_IDLE
    } state_e;

endpackage

// File: rtl/text_ram_writer_if.sv
// Byte-stream input, text RAM write port and cursor/status outputs of the writer.
interface text_ram_writer_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic [4:0] cursor_row;
    logic [4:0] cursor_col;
    logic       busy;

    // master: the byte source / observer; slave: the writer itself
    modport master (
        output in_data, in_valid,
        input  in_ready, ram_addr, ram_din, ram_we, cursor_row, cursor_col, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ram_addr, ram_din, ram_we, cursor_row, cursor_col, busy
    );

endinterface

// File: rtl/text_ram_writer.sv
// Character stream to 32x32 text RAM writer with cursor tracking, control
// codes (LF, CR, BS, FF) and row/screen clearing.
module text_ram_writer
    import text_pkg::*;
#(
    parameter logic [7:0] CLEAR_CHAR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    text_ram_writer_if.slave  bus
);

    state_e     state_q;
    logic [4:0] row_q;
    logic [4:0] col_q;
    logic [9:0] cnt_q;
    logic       we_q;
    logic [9:0] addr_q;
    logic [7:0] din_q;

    localparam logic [4:0] LAST_COL = 5'(TEXT_COLS - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR_SCREEN;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                ST_CLEAR_SCREEN: begin
                    we_q   <= 1'b1;
                    addr_q <= cnt_q;
                    din_q  <= CLEAR_CHAR;
                    // counter wraps back to zero on the final cell
                    cnt_q  <= cnt_q + 10'd1;
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CLEAR_ROW: begin
                    we_q   <= 1'b1;
                    addr_q <= {row_q, cnt_q[4:0]};
                    din_q  <= CLEAR_CHAR;
                    if (cnt_q[4:0] == '1) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_data >= ASCII_PRINT_MIN) begin
                            we_q   <= 1'b1;
                            addr_q <= {row_q, col_q};
                            din_q  <= bus.in_data;
                            if (col_q == LAST_COL) begin
                                col_q   <= '0;
                                row_q   <= row_q + 5'd1;
                                cnt_q   <= '0;
                                state_q <= ST_CLEAR_ROW;
                            end else begin
                                col_q <= col_q + 5'd1;
                            end
                        end else begin
                            case (bus.in_data)
                                ASCII_LF: begin
                                    row_q   <= row_q + 5'd1;
                                    cnt_q   <= '0;
                                    state_q <= ST_CLEAR_ROW;
                                end
                                ASCII_CR: col_q <= '0;
                                ASCII_BS: begin
                                    if (col_q != '0) begin
                                        col_q <= col_q - 5'd1;
                                    end
                                end
                                ASCII_FF: begin
                                    row_q   <= '0;
                                    col_q   <= '0;
                                    cnt_q   <= '0;
                                    state_q <= ST_CLEAR_SCREEN;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state_q <= ST_CLEAR_SCREEN;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.ram_we     = we_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_din    = din_q;
    assign bus.cursor_row = row_q;
    assign bus.cursor_col = col_q;

endmodule

// File: tb/tb_text_ram_writer.sv
// Directed and randomised checks of text_ram_writer against a 32x32 text
// array model; RAM contents are rebuilt from the observed write port.
`timescale 1ns/1ps
module tb_text_ram_writer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    text_ram_writer_if bus ();

    text_ram_writer #(.CLEAR_CHAR(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [7:0]  din;
        int unsigned cyc;
    } wr_t;

    wr_t         wlog[$];
    logic [7:0]  ram [1024];
    logic [7:0]  mdl_mem [1024];
    logic [4:0]  mdl_row;
    logic [4:0]  mdl_col;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.ram_we === 1'b1) begin
            ram[bus.ram_addr] = bus.ram_din;
            wlog.push_back('{bus.ram_addr, bus.ram_din, cyc});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void mdl_advance();
        mdl_row = mdl_row + 5'd1;
        for (int c = 0; c < 32; c++) mdl_mem[{mdl_row, 5'(c)}] = 8'h00;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20) begin
            mdl_mem[{mdl_row, mdl_col}] = b;
            if (mdl_col == 5'd31) begin
                mdl_col = 5'd0;
                mdl_advance();
            end else begin
                mdl_col = mdl_col + 5'd1;
            end
        end else begin
            case (b)
                8'h0A: mdl_advance();
                8'h0D: mdl_col = 5'd0;
                8'h08: if (mdl_col != 5'd0) mdl_col = mdl_col - 5'd1;
                8'h0C: begin
                    mdl_row = 5'd0;
                    mdl_col = 5'd0;
                    for (int a = 0; a < 1024; a++) mdl_mem[a] = 8'h00;
                end
                default: ;
            endcase
        end
    endfunction

    function automatic int unsigned ram_diff();
        int unsigned d = 0;
        for (int a = 0; a < 1024; a++) if (ram[a] !== mdl_mem[a]) d++;
        return d;
    endfunction

    // All bench activity happens 1 ns after the falling edge, after the write capture.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic wait_idle(output int unsigned busy_cycles);
        busy_cycles = 0;
        while (bus.busy !== 1'b0 && busy_cycles < 3000) begin
            tick();
            busy_cycles++;
        end
        if (bus.busy !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_init_seq(input string tag);
        int unsigned bad = 0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'(i) || bus.ram_din !== 8'h00) begin
                if (bad == 0)
                    $display("FAIL %s_seq: write %0d we=%b addr=%0d din=%h required we=1 addr=%0d din=00",
                             tag, i, bus.ram_we, bus.ram_addr, bus.ram_din, i);
                bad++;
            end
            if (i < 1023 && (bus.in_ready !== 1'b0 || bus.busy !== 1'b1)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s_clear: %0d bad cycles required 0", tag, bad);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done: in_ready=%b busy=%b required 1/0", tag, bus.in_ready, bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.ram_we !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_we_off: ram_we=%b required 0", tag, bus.ram_we);
        end
        mdl_row = 5'd0;
        mdl_col = 5'd0;
        for (int a = 0; a < 1024; a++) mdl_mem[a] = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 10'd0 || bus.ram_din !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_port: we=%b addr=%0d din=%h required 0/0/00", bus.ram_we, bus.ram_addr, bus.ram_din);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: in_ready=%b busy=%b required 0/1", bus.in_ready, bus.busy);
        end
        n_cmp++;
        if (bus.cursor_row !== 5'd0 || bus.cursor_col !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_cursor: (%0d,%0d) required (0,0)", bus.cursor_row, bus.cursor_col);
        end
        reset = 1'b0;
        test_init_seq("init");
        n_cmp++;
        if (ram_diff() != 0) begin
            n_bad++;
            $display("FAIL init_ram: %0d cells differ required 0", ram_diff());
        end
    endtask

    task automatic test_single();
        wlog.delete();
        send_byte(8'h41);
        n_cmp++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'd0 || bus.ram_din !== 8'h41) begin
            n_bad++;
            $display("FAIL single_write: we=%b addr=%0d din=%h required 1/0/41", bus.ram_we, bus.ram_addr, bus.ram_din);
        end
        n_cmp++;
        if (bus.cursor_row !== 5'd0 || bus.cursor_col !== 5'd1) begin
            n_bad++;
            $display("FAIL single_cursor: (%0d,%0d) required (0,1)", bus.cursor_row, bus.cursor_col);
        end
        tick();
        n_cmp++;
        if (wlog.size() != 1) begin
            n_bad++;
            $display("FAIL single_count: %0d writes required 1", wlog.size());
        end
    endtask

    task automatic test_line_wrap();
        int unsigned low;
        int unsigned bad = 0;
        wlog.delete();
        send_byte(8'h0D);
        n_cmp++;
        if (bus.cursor_col !== 5'd0 || wlog.size() != 0) begin
            n_bad++;
            $display("FAIL cr_home: col=%0d writes=%0d required 0/0", bus.cursor_col, wlog.size());
        end
        for (int i = 0; i < 32; i++) send_byte(8'h40 + 8'(i));
        wait_idle(low);
        n_cmp++;
        if (low != 32) begin
            n_bad++;
            $display("FAIL wrap_ready_low: %0d cycles required 32", low);
        end
        n_cmp++;
        if (wlog.size() != 64) begin
            n_bad++;
            $display("FAIL wrap_count: %0d writes required 64", wlog.size());
        end else begin
            for (int k = 0; k < 64; k++) begin
                if (wlog[k].addr !== 10'(k) || wlog[k].cyc != wlog[0].cyc + k ||
                    wlog[k].din !== ((k < 32) ? 8'h40 + 8'(k) : 8'h00)) bad++;
            end
            if (bad != 0) begin
                n_bad++;
                $display("FAIL wrap_writes: %0d bad entries required 0", bad);
            end
        end
        n_cmp++;
        if (bus.cursor_row !== 5'd1 || bus.cursor_col !== 5'd0) begin
            n_bad++;
            $display("FAIL wrap_cursor: (%0d,%0d) required (1,0)", bus.cursor_row, bus.cursor_col);
        end
    endtask

    task automatic test_ctrl();
        int unsigned low;
        int unsigned bad = 0;
        for (int i = 0; i < 30; i++) begin
            send_byte(8'h0A);
            wait_idle(low);
        end
        for (int i = 0; i < 5; i++) send_byte(8'h78);
        n_cmp++;
        if (bus.cursor_row !== 5'd31 || bus.cursor_col !== 5'd5) begin
            n_bad++;
            $display("FAIL lf_setup: (%0d,%0d) required (31,5)", bus.cursor_row, bus.cursor_col);
        end
        tick();
        wlog.delete();
        send_byte(8'h0A);
        n_cmp++;
        if (bus.cursor_row !== 5'd0 || bus.cursor_col !== 5'd5) begin
            n_bad++;
            $display("FAIL lf_wrap_cursor: (%0d,%0d) required (0,5)", bus.cursor_row, bus.cursor_col);
        end
        wait_idle(low);
        for (int k = 0; k < 32; k++)
            if (k >= wlog.size() || wlog[k].addr !== 10'(k) || wlog[k].din !== 8'h00) bad++;
        n_cmp++;
        if (bad != 0 || wlog.size() != 32) begin
            n_bad++;
            $display("FAIL lf_clear: %0d writes, %0d bad required 32/0", wlog.size(), bad);
        end
        tick();
        wlog.delete();
        send_byte(8'h0D);
        send_byte(8'h08);
        tick();
        n_cmp++;
        if (bus.cursor_row !== 5'd0 || bus.cursor_col !== 5'd0 || wlog.size() != 0) begin
            n_bad++;
            $display("FAIL cr_bs: (%0d,%0d) writes=%0d required (0,0)/0", bus.cursor_row, bus.cursor_col, wlog.size());
        end
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        send_byte(8'h08);
        send_byte(8'h01);
        send_byte(8'h1F);
        send_byte(8'h20);
        tick();
        n_cmp++;
        if (bus.cursor_col !== 5'd3 || wlog.size() != 4) begin
            n_bad++;
            $display("FAIL bs_ignore: col=%0d writes=%0d required 3/4", bus.cursor_col, wlog.size());
        end
        n_cmp++;
        if (ram[2] !== 8'h20 || ram[0] !== 8'h61) begin
            n_bad++;
            $display("FAIL bs_overwrite: ram[0]=%h ram[2]=%h required 61/20", ram[0], ram[2]);
        end
        n_cmp++;
        if (ram_diff() != 0) begin
            n_bad++;
            $display("FAIL ctrl_ram: %0d cells differ required 0", ram_diff());
        end
    endtask

    task automatic test_ff_reset();
        int unsigned low;
        int unsigned n = 0;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h0A);
            wait_idle(low);
        end
        wlog.delete();
        send_byte(8'h0C);
        n_cmp++;
        if (bus.cursor_row !== 5'd0 || bus.cursor_col !== 5'd0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ff_cursor: (%0d,%0d) busy=%b required (0,0)/1", bus.cursor_row, bus.cursor_col, bus.busy);
        end
        while (wlog.size() < 500 && n < 2000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (wlog.size() != 500 || wlog[499].addr !== 10'd499) begin
            n_bad++;
            $display("FAIL ff_progress: %0d writes required 500 ending at addr 499", wlog.size());
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 10'd0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ff_abort: we=%b addr=%0d busy=%b required 0/0/1", bus.ram_we, bus.ram_addr, bus.busy);
        end
        tick();
        reset = 1'b0;
        test_init_seq("rst");
        n_cmp++;
        if (ram_diff() != 0) begin
            n_bad++;
            $display("FAIL rst_ram: %0d cells differ required 0", ram_diff());
        end
    endtask

    task automatic test_random();
        int unsigned low;
        int unsigned r;
        logic [7:0]  b;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 255));
            else if (r < 78) b = 8'h0A;
            else if (r < 84) b = 8'h0D;
            else if (r < 91) b = 8'h08;
            else if (r < 92) b = 8'h0C;
            else             b = 8'($urandom_range(0, 31));
            repeat ($urandom_range(0, 2)) tick();
            send_byte(b);
            n_cmp++;
            if (bus.cursor_row !== mdl_row || bus.cursor_col !== mdl_col) begin
                n_bad++;
                $display("FAIL rand_cursor: xfer %0d byte %h (%0d,%0d) required (%0d,%0d)",
                         i, b, bus.cursor_row, bus.cursor_col, mdl_row, mdl_col);
            end
            if (i % 50 == 49) begin
                wait_idle(low);
                n_cmp++;
                if (ram_diff() != 0) begin
                    n_bad++;
                    $display("FAIL rand_ram: xfer %0d, %0d cells differ required 0", i, ram_diff());
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int a = 0; a < 1024; a++) ram[a] = 8'hFF;
        test_reset();
        test_single();
        test_line_wrap();
        test_ctrl();
        test_ff_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
